// File: rtl/reg_file.sv
// Two-read, one-write register file with registered read ports and write-through
// bypass. WCOUNT tracks committed writes modulo 256.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic [7:0]        WCOUNT
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;
  logic [7:0]        wcount_q, wcount_d;

  function automatic logic [7:0] inc_wrap(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  // Reads index the post-write array, so a same-edge write is forwarded to both ports.
  always_comb begin
    regs_d = regs_q;
    wcount_d = wcount_q;
    if (WRITE) begin
      regs_d[INADDRESS] = IN;
      wcount_d = inc_wrap(wcount_q);
    end
    out1_d = regs_d[OUT1ADDRESS];
    out2_d = regs_d[OUT2ADDRESS];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out1_q   <= '0;
      out2_q   <= '0;
      wcount_q <= '0;
    end else begin
      regs_q   <= regs_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      wcount_q <= wcount_d;
    end
  end

  assign OUT1   = out1_q;
  assign OUT2   = out2_q;
  assign WCOUNT = wcount_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file plus hand sequences for
// asynchronous reset and write-counter wrap.
module tb_reg_file;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic [7:0] WCOUNT;

  int errors = 0;
  int checks = 0;

  reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .WCOUNT(WCOUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic [2:0] wa;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] ec;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wr, input logic [7:0] din, input logic [2:0] wa,
                              input logic [2:0] a1, input logic [2:0] a2,
                              input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] ec);
    vec_t v;
    v.wr = wr; v.din = din; v.wa = wa; v.a1 = a1; v.a2 = a2;
    v.e1 = e1; v.e2 = e2; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic [7:0] din, input logic [2:0] wa,
                       input logic [2:0] a1, input logic [2:0] a2);
    WRITE = wr; IN = din; INADDRESS = wa; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reads of r0..r7 after reset
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1'b0, 8'h00, 3'd0, 3'(i), 3'(7 - i), 8'h00, 8'h00, 8'd0);
    vecs[8]  = mk(1'b1, 8'h03, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'd1);
    vecs[9]  = mk(1'b1, 8'h01, 3'd2, 3'd0, 3'd0, 8'h00, 8'h00, 8'd2);
    vecs[10] = mk(1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 8'h03, 8'h01, 8'd2);
    vecs[11] = mk(1'b1, 8'h11, 3'd5, 3'd0, 3'd0, 8'h00, 8'h00, 8'd3);
    vecs[12] = mk(1'b1, 8'hA5, 3'd5, 3'd5, 3'd5, 8'hA5, 8'hA5, 8'd4);
    vecs[13] = mk(1'b0, 8'h00, 3'd0, 3'd5, 3'd1, 8'hA5, 8'h03, 8'd4);
    vecs[14] = mk(1'b1, 8'h22, 3'd4, 3'd4, 3'd0, 8'h22, 8'h00, 8'd5);
    vecs[15] = mk(1'b0, 8'hFF, 3'd4, 3'd4, 3'd4, 8'h22, 8'h22, 8'd5);
    vecs[16] = mk(1'b1, 8'h7E, 3'd0, 3'd0, 3'd4, 8'h7E, 8'h22, 8'd6);
    vecs[17] = mk(1'b1, 8'hC3, 3'd3, 3'd3, 3'd2, 8'hC3, 8'h01, 8'd7);
    vecs[18] = mk(1'b0, 8'h00, 3'd0, 3'd0, 3'd3, 8'h7E, 8'hC3, 8'd7);
    vecs[19] = mk(1'b1, 8'h5A, 3'd7, 3'd7, 3'd5, 8'h5A, 8'hA5, 8'd8);

    RESET = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
    #1;
    chk("reset_out1", OUT1, 8'h00);
    chk("reset_out2", OUT2, 8'h00);
    chk("reset_wcount", WCOUNT, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr, vecs[i].din, vecs[i].wa, vecs[i].a1, vecs[i].a2);
      @(negedge CLK);
      chk($sformatf("vec%0d_out1", i), OUT1, vecs[i].e1);
      chk($sformatf("vec%0d_out2", i), OUT2, vecs[i].e2);
      chk($sformatf("vec%0d_wcount", i), WCOUNT, vecs[i].ec);
    end

    // Reset asserted mid-cycle while a write to r7 is pending
    drive(1'b1, 8'h99, 3'd7, 3'd7, 3'd7);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_out1", OUT1, 8'h00);
    chk("async_out2", OUT2, 8'h00);
    chk("async_wcount", WCOUNT, 8'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk($sformatf("hold%0d_out1", c), OUT1, 8'h00);
      chk($sformatf("hold%0d_wcount", c), WCOUNT, 8'd0);
    end
    RESET = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 3'd7, 3'd5);
    @(negedge CLK);
    chk("post_reset_r7", OUT1, 8'h00);
    chk("post_reset_r5", OUT2, 8'h00);
    chk("post_reset_wcount", WCOUNT, 8'd0);

    // First edge after release with bypass
    drive(1'b1, 8'h3C, 3'd6, 3'd6, 3'd7);
    @(negedge CLK);
    chk("release_bypass_out1", OUT1, 8'h3C);
    chk("release_bypass_out2", OUT2, 8'h00);
    chk("release_bypass_wcount", WCOUNT, 8'd1);

    // 255 more writes bring the counter to 0 via 255
    for (int i = 1; i < 256; i++) begin
      drive(1'b1, 8'(i), 3'(i % 8), 3'd0, 3'd0);
      @(negedge CLK);
      if (i == 254) chk("wrap_255", WCOUNT, 8'd255);
    end
    chk("wrap_0", WCOUNT, 8'd0);
    drive(1'b0, 8'h00, 3'd0, 3'd7, 3'd6);
    @(negedge CLK);
    chk("final_r7", OUT1, 8'hFF);
    chk("final_r6", OUT2, 8'hFE);
    chk("final_wcount", WCOUNT, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the register and port data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning the address width, giving 2**ADDR_W = 8 registers.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port IN, input, DATA_W bits: write data, i.e. the ALU result.
REQ-006 The block SHALL have port INADDRESS, input, ADDR_W bits: write register index.
REQ-007 The block SHALL have port WRITE, input, 1 bit: write enable, sampled on the rising CLK edge.
REQ-008 The block SHALL have port OUT1ADDRESS, input, ADDR_W bits: read port 1 register index.
REQ-009 The block SHALL have port OUT2ADDRESS, input, ADDR_W bits: read port 2 register index.
REQ-010 The block SHALL have port OUT1, output, DATA_W bits: registered read data 1, feeding ALU INPUT1.
REQ-011 The block SHALL have port OUT2, output, DATA_W bits: registered read data 2, feeding ALU INPUT2.
REQ-012 The block SHALL have port WCOUNT, output, 8 bits: count of committed writes since reset.

Function
REQ-013 Storage SHALL be 8 registers of DATA_W bits, indices 0-7; all are general-purpose and writable, including index 0.
REQ-014 On a rising CLK edge with RESET=0 and WRITE=1, the register at INADDRESS SHALL take IN.
REQ-015 On a rising CLK edge with WRITE=0, no register SHALL change.
REQ-016 Read latency SHALL be 1 cycle: on each rising edge, OUT1 takes reg[OUT1ADDRESS] and OUT2 takes reg[OUT2ADDRESS], using the addresses sampled at that edge.
REQ-017 Bypass: if WRITE=1 and INADDRESS equals OUT1ADDRESS at the same edge, OUT1 SHALL take IN (the new value), not the old register contents; the same rule SHALL apply independently to OUT2.
REQ-018 When OUT1ADDRESS equals OUT2ADDRESS, OUT1 and OUT2 SHALL carry identical values, with the bypass applied to both.
REQ-019 OUT1 and OUT2 SHALL update every cycle regardless of WRITE; there is no read enable.
REQ-020 WCOUNT SHALL increment by 1 on each edge where a write commits.
REQ-021 WCOUNT SHALL wrap from 255 to 0 with no flag.
REQ-022 Arithmetic SHALL be unsigned and modulo 2**8.
REQ-023 An address input carrying X/Z SHALL be outside the contract; the bench SHALL drive only defined addresses.
REQ-024 Outputs SHALL depend only on state; there SHALL be no combinational path from any input to OUT1, OUT2 or WCOUNT.

Reset
REQ-025 When RESET rises, all 8 registers, OUT1, OUT2 and WCOUNT SHALL go to 0 immediately, without waiting for a CLK edge.
REQ-026 While RESET=1, writes SHALL be ignored and all outputs SHALL hold 0, even if CLK toggles with WRITE=1.
REQ-027 On the first rising edge after RESET falls, normal operation SHALL resume; reads return 0 unless that edge's bypass applies.
REQ-028 If RESET asserts in the middle of a cycle in which WRITE=1, that write SHALL be lost and the target register SHALL read 0.

Verification
REQ-029 Reset then read: pulse RESET, then read addresses 0-7 on both ports over 8 cycles -> every OUT1/OUT2 = 0x00 and WCOUNT = 0.
REQ-030 Write then read: write 0x03 to r1 and 0x01 to r2, then on the next edge set OUT1ADDRESS=1 and OUT2ADDRESS=2 with WRITE=0 -> after 1 cycle OUT1 = 0x03, OUT2 = 0x01, WCOUNT = 2.
REQ-031 Bypass: with r5 = 0x11, set WRITE=1, IN=0xA5, INADDRESS=5, OUT1ADDRESS=5, OUT2ADDRESS=5 -> after that edge OUT1 = OUT2 = 0xA5, and a later read of r5 returns 0xA5.
REQ-032 Write disabled: with r4 = 0x22, set WRITE=0, IN=0xFF, INADDRESS=4 -> r4 stays 0x22 and WCOUNT does not change.
REQ-033 Asynchronous reset mid-cycle: with r7 = 0x5A, assert RESET between clock edges -> OUT1/OUT2 = 0 before the next edge, and r7 reads 0 after release; 256 subsequent writes -> WCOUNT = 0 (wrap).
